// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

    localparam int DIV_W       = 8;
    localparam int DIV_MIN     = 2;
    localparam int DIV_DEFAULT = 3;

    typedef logic [DIV_W-1:0] div_t;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } run_state_e;

    function automatic div_t half(div_t n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_out_stage.sv
// Output phase pair for the divider: posedge phase, negedge half-cycle extension for odd N, ORed.
// The only negedge logic in the block; swap for a dual-edge cell here if one becomes available.
module clk_div_out_stage #(
    parameter bit ODD_RST = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pos_d_i,
    input  logic odd_ld_i,
    input  logic odd_d_i,
    output logic clk_div_o
);

    logic pos_q;
    logic neg_q;
    logic odd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q <= 1'b0;
            odd_q <= ODD_RST;
        end else begin
            pos_q <= pos_d_i;
            if (odd_ld_i) odd_q <= odd_d_i;
        end
    end

    // odd_q only changes at a boundary, where pos_q has been low for a full cycle.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) neg_q <= 1'b0;
        else         neg_q <= pos_q & odd_q;
    end

    assign clk_div_o = pos_q | neg_q;

endmodule

// File: rtl/clk_div_by_n.sv
// Runtime-programmable 50%-duty clock divider: period counter, divisor handshake and run/stop FSM.
module clk_div_by_n #(
    parameter int W           = clk_div_pkg::DIV_W,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] div_i,
    input  logic         div_vld_i,
    output logic         div_rdy_o,
    output logic         div_err_o,
    output logic         clk_div_o,
    output logic         tick_o,
    output logic         running_o
);
    import clk_div_pkg::*;

    localparam logic [W-1:0] N_RST = W'(DIV_DEFAULT);
    localparam logic [W-1:0] N_MIN = W'(DIV_MIN);
    localparam logic [W-1:0] ONE   = W'(1);

    run_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;
    logic         err_q, err_d;
    logic         tick_q, tick_d;
    logic         wrap, bnd, apply, pos_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= STOPPED;
            cnt_q      <= N_RST - ONE;
            n_q        <= N_RST;
            h_q        <= N_RST >> 1;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            h_q        <= h_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        h_d        = h_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = 1'b0;
        tick_d     = 1'b0;
        pos_d      = 1'b0;

        // While stopped cnt sits at N-1, so wrap is always true there.
        wrap  = (cnt_q == n_q - ONE);
        bnd   = wrap && en_i;
        apply = bnd && pend_vld_q;

        case (state_q)
            STOPPED: if (en_i) state_d = RUN;
            RUN:     if (wrap && !en_i) state_d = STOPPED;
        endcase

        if (bnd) begin
            // New period: first cycle is always high since H >= 1 for N >= 2.
            cnt_d  = '0;
            tick_d = 1'b1;
            pos_d  = 1'b1;
            if (pend_vld_q) begin
                n_d        = pend_q;
                h_d        = pend_q >> 1;
                pend_vld_d = 1'b0;
            end
        end else if (state_q == RUN && !wrap) begin
            cnt_d = cnt_q + ONE;
            pos_d = (cnt_d < h_q);
        end

        // Accept only while nothing is pending, so it never collides with apply.
        if (div_vld_i && !pend_vld_q) begin
            if (div_i >= N_MIN) begin
                pend_d     = div_i;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    clk_div_out_stage #(
        .ODD_RST ((DIV_DEFAULT % 2) == 1)
    ) u_out (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .pos_d_i   (pos_d),
        .odd_ld_i  (apply),
        .odd_d_i   (pend_q[0]),
        .clk_div_o (clk_div_o)
    );

    assign div_rdy_o = !pend_vld_q;
    assign div_err_o = err_q;
    assign tick_o    = tick_q;
    assign running_o = (state_q == RUN);

endmodule
